// File: rtl/cpu_sequencer.sv
// Instruction phase sequencer: walks an 8-phase cycle per instruction in
// free-run or single-step mode, with graceful stop, CPU halt and a saturating fetch counter.
module cpu_sequencer #(
   parameter int ALU_PHASE    = 6,
   parameter int FETCH_PHASES = 4
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       start,
   input  logic       step_mode,
   input  logic       stop,
   input  logic       halt,
   input  logic       load_ir,
   output logic       fetch,
   output logic       cntrl_en,
   output logic       alu_en,
   output logic [2:0] phase,
   output logic       running,
   output logic       halted,
   output logic [7:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [2:0] ALU_PH    = 3'(ALU_PHASE);
   localparam logic [2:0] FETCH_LIM = 3'(FETCH_PHASES);
   localparam logic [2:0] LAST_PH   = 3'd7;
   localparam logic [7:0] CNT_MAX   = 8'hFF;

   state_t     state_q, state_d;
   logic [2:0] phase_q, phase_d;
   logic       stop_pend_q, stop_pend_d;
   logic [7:0] count_q, count_d;
   logic       active;

   assign active = (state_q == S_RUN) || (state_q == S_STEP);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      stop_pend_d = stop_pend_q;
      count_d     = count_q;

      if (active && load_ir && (count_q != CNT_MAX)) begin
         count_d = count_q + 8'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            phase_d     = 3'd0;
            stop_pend_d = 1'b0;
            if (start) begin
               state_d = step_mode ? S_STEP : S_RUN;
            end
         end
         S_RUN, S_STEP: begin
            phase_d = phase_q + 3'd1;
            if ((state_q == S_RUN) && stop) begin
               stop_pend_d = 1'b1;
            end
            // Halt outranks the end-of-instruction return to IDLE.
            if (halt) begin
               state_d = S_HALTED;
            end else if ((phase_q == LAST_PH) &&
                         ((state_q == S_STEP) || stop_pend_q)) begin
               state_d     = S_IDLE;
               phase_d     = 3'd0;
               stop_pend_d = 1'b0;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q     <= S_IDLE;
         phase_q     <= 3'd0;
         stop_pend_q <= 1'b0;
         count_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         stop_pend_q <= stop_pend_d;
         count_q     <= count_d;
      end
   end

   // Outputs depend only on registered state, never on inputs directly.
   assign running     = active;
   assign halted      = (state_q == S_HALTED);
   assign cntrl_en    = active;
   assign fetch       = active && (phase_q < FETCH_LIM);
   assign alu_en      = active && (phase_q == ALU_PH);
   assign phase       = phase_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a behavioural model queues the expected
// outputs for each driven cycle, which are popped and compared after the clock edge.
module tb_cpu_sequencer;

   localparam int ALU_PHASE    = 6;
   localparam int FETCH_PHASES = 4;

   logic       clk = 1'b0;
   logic       rst_, start, step_mode, stop, halt, load_ir;
   logic       fetch, cntrl_en, alu_en, running, halted;
   logic [2:0] phase;
   logic [7:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int ph;
      bit run;
      bit hlt;
      bit fe;
      bit ce;
      bit ae;
      int cnt;
   } exp_t;

   exp_t exp_q[$];

   // model state: 0 idle, 1 run, 2 step, 3 halted
   int m_mode = 0;
   int m_ph   = 0;
   bit m_pend = 0;
   int m_cnt  = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(
      .ALU_PHASE   (ALU_PHASE),
      .FETCH_PHASES(FETCH_PHASES)
   ) dut (
      .clk        (clk),
      .rst_       (rst_),
      .start      (start),
      .step_mode  (step_mode),
      .stop       (stop),
      .halt       (halt),
      .load_ir    (load_ir),
      .fetch      (fetch),
      .cntrl_en   (cntrl_en),
      .alu_en     (alu_en),
      .phase      (phase),
      .running    (running),
      .halted     (halted),
      .instr_count(instr_count)
   );

   task automatic chk(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model, wait for the
   // DUT to act on the rising edge, then compare at the next falling edge.
   task automatic cyc(input bit st = 0, input bit sm = 0, input bit sp = 0,
                      input bit hl = 0, input bit li = 0, input bit rs = 0);
      int  nm, nph, nc;
      bit  np, r;
      exp_t e, g;
      rst_ = rs; start = st; step_mode = sm; stop = sp; halt = hl; load_ir = li;

      nm = m_mode; nph = m_ph; np = m_pend; nc = m_cnt;
      if (rs) begin
         nm = 0; nph = 0; np = 0; nc = 0;
      end else begin
         if ((m_mode == 1 || m_mode == 2) && li && m_cnt < 255) nc = m_cnt + 1;
         if (m_mode == 0) begin
            if (st) nm = sm ? 2 : 1;
         end else if (m_mode != 3) begin
            nph = (m_ph + 1) % 8;
            if (m_mode == 1 && sp) np = 1;
            if (hl) nm = 3;
            else if (m_ph == 7 && (m_mode == 2 || m_pend)) begin
               nm = 0; nph = 0; np = 0;
            end
         end
      end
      m_mode = nm; m_ph = nph; m_pend = np; m_cnt = nc;

      r     = (nm == 1 || nm == 2);
      e.ph  = nph;
      e.run = r;
      e.hlt = (nm == 3);
      e.ce  = r;
      e.fe  = r && (nph < FETCH_PHASES);
      e.ae  = r && (nph == ALU_PHASE);
      e.cnt = nc;
      exp_q.push_back(e);

      @(posedge clk);
      @(negedge clk);
      g = exp_q.pop_front();
      chk("phase",       int'(phase),       g.ph);
      chk("running",     int'(running),     int'(g.run));
      chk("halted",      int'(halted),      int'(g.hlt));
      chk("fetch",       int'(fetch),       int'(g.fe));
      chk("cntrl_en",    int'(cntrl_en),    int'(g.ce));
      chk("alu_en",      int'(alu_en),      int'(g.ae));
      chk("instr_count", int'(instr_count), g.cnt);
   endtask

   task automatic idle_n(input int n, input bit li = 0);
      for (int i = 0; i < n; i++) cyc(.li(li));
   endtask

   // Advance until the model reports the wanted phase; a blown budget is an error.
   task automatic to_phase(input int ph);
      int k = 0;
      while (m_ph != ph && k < 16) begin
         cyc();
         k++;
      end
      chk("to_phase_timeout", int'(m_ph == ph), 1);
   endtask

   initial begin
      rst_ = 1'b1; start = 0; step_mode = 0; stop = 0; halt = 0; load_ir = 0;
      @(negedge clk);
      cyc(.rs(1));
      cyc(.rs(1));
      idle_n(2);

      // Free run: full phase walk, then graceful stop requested at phase 2.
      cyc(.st(1));
      idle_n(9);
      to_phase(2);
      cyc(.sp(1));
      idle_n(8);
      chk("stop_to_idle", int'(running), 0);

      // Single step twice, with stray stop pulses that must not latch.
      cyc(.st(1), .sm(1));
      cyc(.sp(1));
      idle_n(8);
      cyc(.sp(1));
      cyc(.st(1), .sm(1));
      idle_n(9);

      // Stop pulsed at phase 7 runs one further instruction; start during run ignored.
      cyc(.st(1));
      cyc(.st(1));
      to_phase(7);
      cyc(.sp(1));
      idle_n(10);

      // Halt together with stop at phase 3; start is ignored while halted.
      cyc(.st(1), .li(1));
      to_phase(3);
      cyc(.sp(1), .hl(1));
      chk("halt_phase", int'(phase), 4);
      cyc(.st(1));
      cyc(.st(1), .sm(1));
      cyc(.sp(1));
      idle_n(2);
      cyc(.rs(1));
      idle_n(2);

      // Halt in the last phase of a step beats the return to IDLE.
      cyc(.st(1), .sm(1));
      to_phase(7);
      cyc(.hl(1));
      idle_n(2);
      cyc(.rs(1));

      // Counter saturation over 300 instructions.
      cyc(.st(1));
      for (int n = 0; n < 300; n++) begin
         to_phase(1);
         cyc(.li(1));
      end
      chk("count_sat", int'(instr_count), 255);
      idle_n(8, 1'b1);

      // Reset mid-instruction, then load_ir while idle must not count.
      to_phase(5);
      cyc(.rs(1));
      idle_n(4, 1'b1);
      cyc(.hl(1));
      idle_n(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
